// File: rtl/app_rd_to_fifo.sv
// rtl/app_rd_to_fifo.sv - pairs 64-bit DDR read beats into 128-bit words and buffers them for the read-data fifo
// Optional macro DDR_RD_BEAT_CHECK_EN: validates app_rd_data_end against the beat position.
module app_rd_to_fifo #(
  parameter int BUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic         app_rd_data_end,
  input  logic         rd_issued,
  output logic         rd_issue_ok,
  input  logic         rd_fifo_full,
  output logic         put_rd_data,
  output logic [127:0] rd_data_out,
  output logic         rd_err
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {BEAT0, BEAT1} beat_e;

  beat_e          state_q, state_d;
  logic [63:0]    low_q, low_d;
  logic [127:0]   buf_q [BUF_DEPTH];
  logic [127:0]   buf_d [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic [CW-1:0]  out_q, out_d;
  logic           err_q, err_d;

  logic           pop;
  logic           full_no_pop;
  logic           beat_ok;
  logic           bad_end;
  logic           word_done;

`ifdef DDR_RD_BEAT_CHECK_EN
  assign bad_end = beat_ok && (app_rd_data_end != (state_q == BEAT1));
`else
  logic unused_end;
  assign unused_end = app_rd_data_end;
  assign bad_end    = 1'b0;
`endif

  // A full buffer still accepts a word when the head is leaving on the same edge.
  assign pop         = (occ_q != '0) && !rd_fifo_full;
  assign full_no_pop = (occ_q == CW'(BUF_DEPTH)) && !pop;
  assign beat_ok     = app_rd_data_valid && (out_q != '0) && !full_no_pop;

  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    buf_d     = buf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    word_done = 1'b0;

    if (app_rd_data_valid && !beat_ok) begin
      err_d = 1'b1;
    end else if (bad_end) begin
      err_d   = 1'b1;
      state_d = BEAT0;
    end else if (beat_ok) begin
      if (state_q == BEAT0) begin
        low_d   = app_rd_data;
        state_d = BEAT1;
      end else begin
        word_done       = 1'b1;
        state_d         = BEAT0;
        buf_d[wr_ptr_q] = {app_rd_data, low_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    occ_d = occ_q + CW'(word_done) - CW'(pop);
    out_d = out_q + CW'(rd_issued) - CW'(word_done);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BEAT0;
      low_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      err_q    <= err_d;
      buf_q    <= buf_d;
    end
  end

  // Reserving room for every outstanding word keeps the buffer from ever overflowing.
  assign rd_issue_ok = ({1'b0, out_q} + {1'b0, occ_q}) < (CW + 1)'(BUF_DEPTH);
  assign put_rd_data = pop;
  assign rd_data_out = (occ_q != '0) ? buf_q[rd_ptr_q] : '0;
  assign rd_err      = err_q;

endmodule
